// File: rtl/tl_intersection_model_pkg.sv
// ---------------------------------------------------------------------------
// tl_pkg
// Shared definitions for the traffic light controller and the intersection
// model it drives: the 2-bit light encoding and small decode helpers.
//
// Contents:
//   light_t           2-bit light code type
//   TL_GREEN/...      light encoding constants
//   light_is_green()  1 when the light lets cars depart
//   light_is_red()    1 when the light is treated as red (red or illegal)
//   light_is_illegal() 1 for the reserved 2'b11 code
// ---------------------------------------------------------------------------
package tl_pkg;

    typedef logic [1:0] light_t;

    localparam light_t TL_GREEN   = 2'b00;
    localparam light_t TL_YELLOW  = 2'b01;
    localparam light_t TL_RED     = 2'b10;
    localparam light_t TL_ILLEGAL = 2'b11;

    // Only a genuine green drains a queue; yellow means stop.
    function automatic logic light_is_green(input light_t light);
        return (light == TL_GREEN);
    endfunction

    // The illegal code is folded into red so that a broken controller
    // cannot let cars through or trigger a conflict with it; it is
    // reported separately through the illegal flag.
    function automatic logic light_is_red(input light_t light);
        return (light == TL_RED) || (light == TL_ILLEGAL);
    endfunction

    function automatic logic light_is_illegal(input light_t light);
        return (light == TL_ILLEGAL);
    endfunction

endpackage : tl_pkg

// File: rtl/tl_intersection_model_if.sv
// ---------------------------------------------------------------------------
// tl_intersection_model_if
// Signal bundle between a traffic light controller (or a bench standing in
// for it) and the intersection model.
//
// Signals:
//   La, Lb          light codes for street A / B (controller -> model)
//   arr_a, arr_b    one-cycle car arrival pulses (environment -> model)
//   Ta, Tb          traffic sensors, queue nonzero (model -> controller)
//   q_a, q_b        cars waiting per street
//   dep_a, dep_b    wrapping count of departed cars per street
//   ovf             sticky: arrival dropped at a full queue
//   conflict        sticky: both lights non-red in one cycle
//   illegal         sticky: 2'b11 seen on either light
//
// Modports:
//   master  drives lights and arrivals, observes the model outputs
//   slave   the intersection model itself
// ---------------------------------------------------------------------------
interface tl_intersection_model_if #(
    parameter int QW = 4,
    parameter int CW = 8
);
    import tl_pkg::*;

    light_t          La;
    light_t          Lb;
    logic            arr_a;
    logic            arr_b;
    logic            Ta;
    logic            Tb;
    logic [QW-1:0]   q_a;
    logic [QW-1:0]   q_b;
    logic [CW-1:0]   dep_a;
    logic [CW-1:0]   dep_b;
    logic            ovf;
    logic            conflict;
    logic            illegal;

    modport master (
        output La, Lb, arr_a, arr_b,
        input  Ta, Tb, q_a, q_b, dep_a, dep_b, ovf, conflict, illegal
    );

    modport slave (
        input  La, Lb, arr_a, arr_b,
        output Ta, Tb, q_a, q_b, dep_a, dep_b, ovf, conflict, illegal
    );

endinterface : tl_intersection_model_if

// File: rtl/tl_intersection_model_lane.sv
// ---------------------------------------------------------------------------
// tl_lane_queue
// One street of the intersection: a car queue fed by arrival pulses and
// drained by one car every DEPART_CYCLES consecutive green cycles, plus a
// wrapping departed-car counter and a sticky overflow flag.
//
// Parameters:
//   QW             queue counter width (capacity 2^QW-1)
//   DEPART_CYCLES  green cycles needed per departing car (>= 1)
//   CW             departed-car counter width
//
// Ports:
//   clk    system clock, rising edge
//   reset  synchronous active-high reset
//   green  light for this street is green this cycle
//   arr    one car arrives this cycle
//   q      cars waiting (registered)
//   dep    cars departed, wraps modulo 2^CW (registered)
//   ovf    sticky: an arrival was dropped at full queue
// ---------------------------------------------------------------------------
module tl_lane_queue #(
    parameter int QW            = 4,
    parameter int DEPART_CYCLES = 3,
    parameter int CW            = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          green,
    input  logic          arr,
    output logic [QW-1:0] q,
    output logic [CW-1:0] dep,
    output logic          ovf
);

    // A single-cycle departure period still needs a 1-bit timer to keep
    // the port widths legal; it simply stays at 0.
    localparam int TW = (DEPART_CYCLES > 1) ? $clog2(DEPART_CYCLES) : 1;

    localparam logic [TW-1:0] T_LAST = TW'(DEPART_CYCLES - 1);
    localparam logic [TW-1:0] T_ONE  = TW'(1);
    localparam logic [QW-1:0] Q_FULL = '1;
    localparam logic [QW-1:0] Q_ONE  = QW'(1);
    localparam logic [CW-1:0] C_ONE  = CW'(1);

    logic [TW-1:0] t_reg,   t_next;
    logic [QW-1:0] q_reg,   q_next;
    logic [CW-1:0] dep_reg, dep_next;
    logic          ovf_reg, ovf_next;

    logic active;
    logic fire;

    always_ff @(posedge clk) begin
        if (reset) begin
            t_reg   <= '0;
            q_reg   <= '0;
            dep_reg <= '0;
            ovf_reg <= 1'b0;
        end else begin
            t_reg   <= t_next;
            q_reg   <= q_next;
            dep_reg <= dep_next;
            ovf_reg <= ovf_next;
        end
    end

    always_comb begin
        t_next   = t_reg;
        q_next   = q_reg;
        dep_next = dep_reg;
        ovf_next = ovf_reg;

        // The timer only runs while there is a car to move; an empty queue
        // or any non-green cycle throws away partial progress.
        active = green && (q_reg != '0);
        fire   = active && (t_reg == T_LAST);

        if (!active || fire) begin
            t_next = '0;
        end else begin
            t_next = t_reg + T_ONE;
        end

        // Arrival and departure in the same cycle cancel, which is also
        // how a full queue accepts a car without flagging overflow.
        unique case ({arr, fire})
            2'b10: begin
                if (q_reg == Q_FULL) begin
                    ovf_next = 1'b1;
                end else begin
                    q_next = q_reg + Q_ONE;
                end
            end
            2'b01:   q_next = q_reg - Q_ONE;
            default: q_next = q_reg;
        endcase

        if (fire) begin
            dep_next = dep_reg + C_ONE;
        end
    end

    assign q   = q_reg;
    assign dep = dep_reg;
    assign ovf = ovf_reg;

endmodule : tl_lane_queue

// File: rtl/tl_intersection_model.sv
// ---------------------------------------------------------------------------
// tl_intersection_model
// Closed-loop plant for a two-street traffic light controller. Two identical
// lane queues are driven by the light outputs; this level decodes the
// traffic sensors from the queue registers and watches the lights for
// protocol violations (conflicting non-red lights, illegal encodings).
//
// Parameters:
//   QW             queue counter width (capacity 2^QW-1 cars per street)
//   DEPART_CYCLES  green cycles per departing car (>= 1)
//   CW             departed-car counter width
//
// Ports:
//   clk    system clock, rising edge
//   reset  synchronous active-high reset
//   bus    slave side of tl_intersection_model_if (lights and arrivals in;
//          sensors, queue depths, departure counts and flags out)
// ---------------------------------------------------------------------------
module tl_intersection_model
    import tl_pkg::*;
#(
    parameter int QW            = 4,
    parameter int DEPART_CYCLES = 3,
    parameter int CW            = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    tl_intersection_model_if.slave  bus
);

    localparam int NLANE = 2;

    // Index 0 is street A, index 1 is street B.
    light_t        lane_light  [NLANE];
    logic          lane_arr    [NLANE];
    logic          lane_green  [NLANE];
    logic [QW-1:0] lane_q      [NLANE];
    logic [CW-1:0] lane_dep    [NLANE];
    logic          lane_ovf    [NLANE];
    logic          lane_sensor [NLANE];

    logic conflict_reg, conflict_next;
    logic illegal_reg,  illegal_next;

    assign lane_light[0] = bus.La;
    assign lane_light[1] = bus.Lb;
    assign lane_arr[0]   = bus.arr_a;
    assign lane_arr[1]   = bus.arr_b;

    genvar gi;
    generate
        for (gi = 0; gi < NLANE; gi++) begin : g_lane
            assign lane_green[gi] = light_is_green(lane_light[gi]);

            tl_lane_queue #(
                .QW            (QW),
                .DEPART_CYCLES (DEPART_CYCLES),
                .CW            (CW)
            ) u_lane (
                .clk   (clk),
                .reset (reset),
                .green (lane_green[gi]),
                .arr   (lane_arr[gi]),
                .q     (lane_q[gi]),
                .dep   (lane_dep[gi]),
                .ovf   (lane_ovf[gi])
            );

            // Decoded straight from the queue register, so the sensor drops
            // on the same edge that removes the last car.
            assign lane_sensor[gi] = (lane_q[gi] != '0);
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            conflict_reg <= 1'b0;
            illegal_reg  <= 1'b0;
        end else begin
            conflict_reg <= conflict_next;
            illegal_reg  <= illegal_next;
        end
    end

    always_comb begin
        conflict_next = conflict_reg;
        illegal_next  = illegal_reg;

        // Yellow counts as a go signal for conflict purposes.
        if (!light_is_red(lane_light[0]) && !light_is_red(lane_light[1])) begin
            conflict_next = 1'b1;
        end
        if (light_is_illegal(lane_light[0]) || light_is_illegal(lane_light[1])) begin
            illegal_next = 1'b1;
        end
    end

    assign bus.Ta       = lane_sensor[0];
    assign bus.Tb       = lane_sensor[1];
    assign bus.q_a      = lane_q[0];
    assign bus.q_b      = lane_q[1];
    assign bus.dep_a    = lane_dep[0];
    assign bus.dep_b    = lane_dep[1];
    assign bus.ovf      = lane_ovf[0] | lane_ovf[1];
    assign bus.conflict = conflict_reg;
    assign bus.illegal  = illegal_reg;

endmodule : tl_intersection_model

// File: tb/tb_tl_intersection_model.sv
// ---------------------------------------------------------------------------
// tb_tl_intersection_model
// Scoreboard bench for the intersection model. A driver applies lights and
// arrivals each cycle, advances a car-counting reference model and queues
// the expected outputs; a monitor pops one entry per cycle and compares.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_tl_intersection_model;

    localparam int QW  = 4;
    localparam int DC  = 3;
    localparam int CW  = 8;
    localparam int CAP = (1 << QW) - 1;

    localparam logic [1:0] G = 2'b00;
    localparam logic [1:0] Y = 2'b01;
    localparam logic [1:0] R = 2'b10;
    localparam logic [1:0] X = 2'b11;

    typedef struct {
        int qa;
        int qb;
        int da;
        int db;
        bit ovf;
        bit conf;
        bit ill;
    } exp_t;

    logic clk;
    logic reset;

    exp_t sb[$];
    int   n_checks;
    int   n_errors;

    // Reference model state: cars waiting, green cycles accumulated
    // toward the next departure, cars departed.
    int m_q[2];
    int m_green_run[2];
    int m_dep[2];
    bit m_ovf;
    bit m_conf;
    bit m_ill;

    tl_intersection_model_if #(.QW(QW), .CW(CW)) bus ();

    tl_intersection_model #(
        .QW            (QW),
        .DEPART_CYCLES (DC),
        .CW            (CW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_update(input logic [1:0] la, input logic [1:0] lb,
                                input bit aa, input bit ab, input bit rst);
        logic [1:0] lt[2];
        bit         ar[2];
        bit         go;
        exp_t       e;
        lt[0] = la; lt[1] = lb;
        ar[0] = aa; ar[1] = ab;
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                m_q[i] = 0; m_green_run[i] = 0; m_dep[i] = 0;
            end
            m_ovf = 0; m_conf = 0; m_ill = 0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                go = 0;
                if (lt[i] == G && m_q[i] > 0) begin
                    m_green_run[i]++;
                    if (m_green_run[i] == DC) begin
                        go = 1;
                        m_green_run[i] = 0;
                    end
                end else begin
                    m_green_run[i] = 0;
                end
                if (ar[i] && !go) begin
                    if (m_q[i] == CAP) m_ovf = 1;
                    else m_q[i]++;
                end else if (go && !ar[i]) begin
                    m_q[i]--;
                end
                if (go) m_dep[i] = (m_dep[i] + 1) % (1 << CW);
            end
            if ((la == G || la == Y) && (lb == G || lb == Y)) m_conf = 1;
            if (la == X || lb == X) m_ill = 1;
        end
        e.qa = m_q[0]; e.qb = m_q[1];
        e.da = m_dep[0]; e.db = m_dep[1];
        e.ovf = m_ovf; e.conf = m_conf; e.ill = m_ill;
        @(posedge clk);
        sb.push_back(e);
    endtask

    // One clock cycle of stimulus: drive after the falling edge, let the
    // DUT sample on the rising edge, then queue the expected state.
    task automatic step(input logic [1:0] la, input logic [1:0] lb,
                        input bit aa, input bit ab, input bit rst);
        @(negedge clk);
        bus.La    = la;
        bus.Lb    = lb;
        bus.arr_a = aa;
        bus.arr_b = ab;
        reset     = rst;
        model_update(la, lb, aa, ab, rst);
    endtask

    task automatic idle_reset();
        step(R, R, 0, 0, 1);
    endtask

    // Monitor: one expected entry per clock, compared away from the edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("q_a",      int'(bus.q_a),      e.qa);
                chk("q_b",      int'(bus.q_b),      e.qb);
                chk("Ta",       int'(bus.Ta),       int'(e.qa != 0));
                chk("Tb",       int'(bus.Tb),       int'(e.qb != 0));
                chk("dep_a",    int'(bus.dep_a),    e.da);
                chk("dep_b",    int'(bus.dep_b),    e.db);
                chk("ovf",      int'(bus.ovf),      int'(e.ovf));
                chk("conflict", int'(bus.conflict), int'(e.conf));
                chk("illegal",  int'(bus.illegal),  int'(e.ill));
                $display("cyc q_a=%0d q_b=%0d dep_a=%0d dep_b=%0d ovf=%0b conf=%0b ill=%0b",
                         bus.q_a, bus.q_b, bus.dep_a, bus.dep_b,
                         bus.ovf, bus.conflict, bus.illegal);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [1:0] la;
        logic [1:0] lb;
        int         hold;
        int         pick;
        n_checks = 0;
        n_errors = 0;
        reset     = 1'b1;
        bus.La    = G;
        bus.Lb    = G;
        bus.arr_a = 1'b0;
        bus.arr_b = 1'b0;

        // Reset overrides arrivals and green lights.
        step(G, G, 1, 1, 1);
        step(G, G, 1, 1, 1);
        step(R, R, 1, 0, 0);
        step(R, R, 0, 0, 0);

        // Five cars on A, then a 15-cycle green drains them.
        idle_reset();
        repeat (5) step(R, R, 1, 0, 0);
        repeat (15) step(G, R, 0, 0, 0);

        // Saturate A, then arrive during departures at full.
        idle_reset();
        repeat (16) step(R, R, 1, 0, 0);
        repeat (7) step(G, R, 1, 0, 0);

        // Arrivals every cycle while draining from two cars.
        idle_reset();
        repeat (2) step(R, R, 1, 0, 0);
        repeat (9) step(G, R, 1, 0, 0);

        // Green interrupted by a yellow cycle restarts the timer.
        idle_reset();
        repeat (3) step(R, R, 1, 0, 0);
        repeat (2) step(G, R, 0, 0, 0);
        step(Y, R, 0, 0, 0);
        repeat (5) step(G, R, 0, 0, 0);

        // Conflict then illegal on B with cars waiting; flags stay sticky.
        idle_reset();
        repeat (2) step(R, R, 0, 1, 0);
        step(Y, G, 0, 0, 0);
        repeat (4) step(R, X, 0, 0, 0);
        repeat (3) step(R, R, 0, 0, 0);
        idle_reset();
        step(R, R, 0, 0, 0);

        // Randomised traffic with mostly legal phases.
        for (int n = 0; n < 600; n++) begin
            pick = $urandom_range(0, 9);
            hold = $urandom_range(1, 8);
            if (pick <= 3)      begin la = G; lb = R; end
            else if (pick == 4) begin la = Y; lb = R; end
            else if (pick <= 7) begin la = R; lb = G; end
            else if (pick == 8) begin la = R; lb = Y; end
            else begin
                la = 2'($urandom_range(0, 3));
                lb = 2'($urandom_range(0, 3));
            end
            for (int h = 0; h < hold; h++) begin
                step(la, lb, $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
                     $urandom_range(0, 199) == 0);
            end
        end

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_tl_intersection_model

// File: doc/tl_intersection_model.md
# tl_intersection_model

Behavioural-but-synthesizable model of the two-street intersection that the traffic light controller drives. It closes the loop around the controller: it consumes the light outputs La/Lb, keeps a car queue per street fed by arrival pulses, drains each queue only while its light is green, and drives the traffic sensors Ta/Tb back into the controller. It also flags protocol violations on the light outputs (conflicting greens, illegal encodings) so closed-loop benches can self-check.

## Interface
- QW, 4: queue counter width; capacity 2^QW−1 cars per street
- DEPART_CYCLES, 3: green cycles per departing car (≥1)
- CW, 8: departed-car counter width
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- La  in  2  street A light: 2'b00 green, 2'b01 yellow, 2'b10 red, 2'b11 illegal
- Lb  in  2  street B light, same encoding
- arr_a  in  1  one car arrives on A this cycle
- arr_b  in  1  one car arrives on B this cycle
- Ta  out  1  traffic present on A (queue A nonzero)
- Tb  out  1  traffic present on B
- q_a  out  QW  cars waiting on A
- q_b  out  QW  cars waiting on B
- dep_a  out  CW  cars departed from A, wraps modulo 2^CW
- dep_b  out  CW  cars departed from B, wraps
- ovf  out  1  sticky: an arrival was dropped at full queue
- conflict  out  1  sticky: both lights non-red in the same cycle
- illegal  out  1  sticky: 2'b11 seen on La or Lb

## Operation
- Per street, identical lane logic; A shown, B symmetric.
- Departure timer t_a (width ≥ clog2(DEPART_CYCLES)): increments each cycle La==green and q_a!=0; at t_a==DEPART_CYCLES−1 a departure fires and t_a returns to 0. When La!=green or q_a==0, t_a clears to 0.
- Yellow and red: no departures; yellow is treated as stop.
- Queue update: arrival only → q_a+1; departure only → q_a−1; both → unchanged; neither → unchanged.
- Full (q_a==2^QW−1) with arrival and no departure: q_a holds, ovf sets. Arrival with simultaneous departure at full is accepted (net unchanged), no ovf.
- Empty: no departure possible (timer held at 0), q_a never underflows.
- dep_a increments by 1 per departure, wraps 2^CW−1 → 0, no flag.
- Ta = (q_a != 0), decoded directly from the q_a register.
- conflict sets when La!=red and Lb!=red in the same cycle (yellow counts as non-red); illegal counts as red for conflict and departure purposes but sets illegal.
- Sticky flags clear only on reset.

## Timing
- Reset (clk edge with reset=1): q_a, q_b, t_a, t_b, dep_a, dep_b = 0; Ta=Tb=0; ovf=conflict=illegal=0. Reset overrides same-cycle arrivals and lights; mid-operation reset discards queues and timers.
- Arrival: arr_a sampled at edge k → q_a and Ta updated after edge k (one-cycle latency).
- Departure: with La green and q_a≥1 continuously from edge k, departures take effect at edges k+DEPART_CYCLES−1, k+2·DEPART_CYCLES−1, …; q_a and dep_a update on the same edge.
- Green interrupted (La leaves green) for even one cycle: partial timer progress lost.
- Flags set one cycle after the sampled violation.
- Ta/Tb deassert on the edge the last car departs, so the controller sees no traffic the following cycle.

## Structure
- Shared package tl_pkg: light encoding constants TL_GREEN=2'b00, TL_YELLOW=2'b01, TL_RED=2'b10, TL_ILLEGAL=2'b11; same package used by the controller.
- Sub-module tl_lane_queue (params QW, DEPART_CYCLES, CW): one lane's timer, queue, departure counter and overflow; instantiated twice.
- Top holds conflict/illegal checks and sensor decode only.

## Test plan
- Reset with arr_a=arr_b=1, La=Lb=green → after release all outputs 0; first arrival next edge gives q_a=1, Ta=1.
- La=red, 5 arr_a pulses, then La=green for 15 cycles (DEPART_CYCLES=3) → q_a 5→0 at edges 2,5,8,11,14 after green start; dep_a=5; Ta falls with last departure.
- QW=4, 16 arr_a pulses with La=red → q_a saturates at 15, ovf=1 after the 16th; then arr_a with concurrent departure at 15 → q_a stays 15, no new effect.
- La=green, q_a=2, arrivals every cycle → q_a unchanged on departure edges, +1 on others.
- La=green, green dropped to yellow after 2 cycles and restored → timer restarts; first departure 3 cycles after restore.
- La=yellow, Lb=green for one cycle → conflict=1; Lb=2'b11 → illegal=1, no B departures; both persist until reset.
